// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg: shared constants and types for the EX hazard controller.
//   HZ_REG_ADDR_WIDTH : default register index width
//   hz_state_e        : stall/flush sequencer states
package ex_hazard_ctrl_pkg;

  localparam int HZ_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_FLUSH    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/ex_hazard_ctrl_hz_scoreboard.sv
// hz_scoreboard: two-slot (EX, MEM) destination scoreboard plus the
// load-use forward compare feeding the registered MEM->ALU operand selects.
//   clk, rst_n           : clock, synchronous active-low reset
//   advance              : pipeline moves this edge (0 = frozen)
//   bubble               : NOP goes into ID/EX this edge
//   id_*                 : decoded fields of the instruction in ID
//   fwd_a, fwd_b         : registered EX operand selects
module hz_scoreboard
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int AW = HZ_REG_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          bubble,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_is_load,
  output logic          fwd_a,
  output logic          fwd_b
);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          reg_write;
    logic          is_load;
  } slot_t;

  // vld_pipe[0] = EX slot valid, vld_pipe[1] = MEM slot valid
  logic [1:0] vld_pipe;
  slot_t      ex_q, mem_q;
  logic       ex_ld_wr, fwd_a_d, fwd_b_d;
  logic       unused_mem;

  assign ex_ld_wr = vld_pipe[0] & ex_q.is_load & ex_q.reg_write;
  // x0 is hardwired zero, so a load targeting it never forwards
  assign fwd_a_d  = id_uses_rs1 & ex_ld_wr & (ex_q.rd == id_rs1) & (id_rs1 != '0);
  assign fwd_b_d  = id_uses_rs2 & ex_ld_wr & (ex_q.rd == id_rs2) & (id_rs2 != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      fwd_a    <= 1'b0;
      fwd_b    <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[0], id_valid & ~bubble};
      mem_q    <= ex_q;
      ex_q     <= '{rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
      // a bubble edge puts a NOP in EX, which must not steer the ALU
      fwd_a    <= fwd_a_d & ~bubble;
      fwd_b    <= fwd_b_d & ~bubble;
    end
  end

  // MEM slot is tracked for pipeline bookkeeping; no output consumes it yet
  assign unused_mem = ^{vld_pipe[1], mem_q};

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage hazard controller. Sequences data-memory wait
// stalls and post-flush bubbles, and owns the load-use forward scoreboard.
//   clk, rst_n                 : clock, synchronous active-low reset
//   id_*                       : ID decode fields
//   mem_access, dm_ready       : data-memory handshake of the MEM instruction
//   flush_req                  : taken branch/jump pulse from EX
//   stall, bubble, flush       : combinational pipeline controls
//   is_MEM_forward_ALU_A/B     : registered EX operand selects
//   dm_timeout                 : sticky memory wait timeout
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
  parameter int FLUSH_CYCLES   = 2,
  parameter int WAIT_LIMIT     = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      mem_access,
  input  logic                      dm_ready,
  input  logic                      flush_req,
  output logic                      stall,
  output logic                      bubble,
  output logic                      flush,
  output logic                      is_MEM_forward_ALU_A,
  output logic                      is_MEM_forward_ALU_B,
  output logic                      dm_timeout
);

  localparam int             WW      = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0]  WL      = WW'(WAIT_LIMIT);
  localparam logic [WW-1:0]  WL_M1   = WW'(WAIT_LIMIT - 1);
  localparam logic [1:0]     FC_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_e     state_q, state_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic [WW-1:0] wcnt_q;
  logic          dm_wait;

  assign dm_wait = mem_access & ~dm_ready;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (dm_wait) begin
          stall   = 1'b1;
          state_d = HZ_MEM_WAIT;
          pend_d  = flush_req;
        end else if (flush_req) begin
          state_d = HZ_FLUSH;
          fcnt_d  = FC_LOAD;
        end
      end
      HZ_MEM_WAIT: begin
        // MEM instruction is frozen, so only dm_ready matters here
        if (!dm_ready) begin
          stall  = 1'b1;
          pend_d = pend_q | flush_req;
        end else if (pend_q | flush_req) begin
          state_d = HZ_FLUSH;
          fcnt_d  = FC_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (flush_req) fcnt_d = FC_LOAD;
        if (dm_wait) begin
          // memory wait outranks bubbling: hold everything, count frozen
          stall = 1'b1;
        end else begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (!flush_req) begin
            if (fcnt_q == 2'd0) state_d = HZ_RUN;
            else                fcnt_d  = fcnt_q - 2'd1;
          end
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HZ_RUN;
      fcnt_q     <= 2'd0;
      pend_q     <= 1'b0;
      wcnt_q     <= '0;
      dm_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      // counts every memory-wait cycle, including the one that enters
      // MEM_WAIT, so the flag rises at the end of the WAIT_LIMIT-th cycle
      if (stall) wcnt_q <= (wcnt_q == WL) ? wcnt_q : wcnt_q + 1'b1;
      else       wcnt_q <= '0;
      if (stall && wcnt_q >= WL_M1) dm_timeout <= 1'b1;
    end
  end

  hz_scoreboard #(.AW(REG_ADDR_WIDTH)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (~stall),
    .bubble       (bubble),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .fwd_a        (is_MEM_forward_ALU_A),
    .fwd_b        (is_MEM_forward_ALU_B)
  );

endmodule
